// File: rtl/ultrasonic_sensor_emulator.sv
// HC-SR04 responder model: qualifies trig, waits the response delay, then drives echo
// for a width proportional to distance_cm. Optional trig synchroniser: ULTRASONIC_EMU_SYNC_EN.
module ultrasonic_sensor_emulator #(
  parameter int unsigned clk_frequency     = 50000000,
  parameter int unsigned distance_width    = 9,
  parameter int unsigned max_range_cm      = 400,
  parameter int unsigned min_trig_us       = 10,
  parameter int unsigned response_delay_us = 250,
  parameter int unsigned timeout_us        = 38000,
  parameter int unsigned holdoff_us        = 10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trig,
  input  logic [distance_width-1:0] distance_cm,
  output logic                      echo,
  output logic                      busy,
  output logic                      short_trig
);

  localparam int unsigned cycles_per_us   = clk_frequency / 1000000;
  localparam int unsigned cycles_per_cm   = clk_frequency * 2 / 343 / 100;
  localparam int unsigned min_trig_cycles = min_trig_us * cycles_per_us;
  localparam int unsigned delay_cycles    = response_delay_us * cycles_per_us;
  localparam int unsigned timeout_cycles  = timeout_us * cycles_per_us;
  localparam int unsigned holdoff_cycles  = holdoff_us * cycles_per_us;

  localparam int unsigned max_th  = (timeout_cycles > holdoff_cycles) ? timeout_cycles : holdoff_cycles;
  localparam int unsigned max_dm  = (delay_cycles > min_trig_cycles) ? delay_cycles : min_trig_cycles;
  localparam int unsigned cnt_max = (max_th > max_dm) ? max_th : max_dm;
  localparam int unsigned cnt_w   = $clog2(cnt_max + 1);
  localparam int unsigned pre_w   = $clog2(cycles_per_cm + 1);

  localparam logic [cnt_w-1:0] trig_min    = cnt_w'(min_trig_cycles);
  // The TRIG-entry cycle is itself a high cycle, so the count lags the true width by one.
  localparam logic [cnt_w-1:0] trig_last   = cnt_w'(min_trig_cycles - 1);
  localparam logic [cnt_w-1:0] delay_last  = cnt_w'(delay_cycles - 1);
  localparam logic [cnt_w-1:0] timeout_last = cnt_w'(timeout_cycles - 1);
  localparam logic [cnt_w-1:0] hold_last   = cnt_w'(holdoff_cycles - 1);
  localparam logic [pre_w-1:0] pre_last    = pre_w'(cycles_per_cm - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  logic trig_s;

`ifdef ULTRASONIC_EMU_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], trig};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= sync_d;
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trig;
`endif

  state_t                    state_q, state_d;
  logic [cnt_w-1:0]          cnt_q, cnt_d;
  logic [pre_w-1:0]          pre_q, pre_d;
  logic [distance_width-1:0] cm_q, cm_d;
  logic                      long_q, long_d;
  logic                      echo_q, echo_d;
  logic                      busy_q, busy_d;
  logic                      short_q, short_d;
  logic                      trig_prev_q, trig_prev_d;
  logic                      trig_rise, trig_fall;

  assign trig_rise = trig_s & ~trig_prev_q;
  assign trig_fall = ~trig_s & trig_prev_q;

  // Next-state and counter control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    cm_d        = cm_q;
    long_d      = long_q;
    echo_d      = echo_q;
    busy_d      = busy_q;
    short_d     = 1'b0;
    trig_prev_d = trig_s;

    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          cnt_d   = '0;
          state_d = TRIG;
        end
      end

      TRIG: begin
        if (trig_fall) begin
          if (cnt_q >= trig_last) begin
            cm_d    = (distance_cm == '0) ? distance_width'(1) : distance_cm;
            long_d  = 32'(distance_cm) > max_range_cm;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = DELAY;
          end else begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end else if (trig_s && (cnt_q < trig_min)) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end

      DELAY: begin
        if (cnt_q == delay_last) begin
          echo_d  = 1'b1;
          cnt_d   = '0;
          pre_d   = '0;
          state_d = ECHO;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end

      ECHO: begin
        if (long_q) begin
          if (cnt_q == timeout_last) begin
            echo_d  = 1'b0;
            cnt_d   = '0;
            state_d = HOLDOFF;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end else if (pre_q == pre_last) begin
          // One centimetre of round-trip time elapsed
          pre_d = '0;
          cm_d  = cm_q - distance_width'(1);
          if (cm_q == distance_width'(1)) begin
            echo_d  = 1'b0;
            cnt_d   = '0;
            state_d = HOLDOFF;
          end
        end else begin
          pre_d = pre_q + pre_w'(1);
        end
      end

      HOLDOFF: begin
        if (cnt_q == hold_last) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      cm_q        <= '0;
      long_q      <= 1'b0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      short_q     <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      cm_q        <= cm_d;
      long_q      <= long_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      short_q     <= short_d;
      trig_prev_q <= trig_prev_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign short_trig = short_q;

endmodule

// File: tb/tb_ultrasonic_sensor_emulator.sv
// Directed bench for ultrasonic_sensor_emulator, run at a scaled 1 MHz clock so every
// scenario fits a short simulation; expected widths are hand-derived from the parameters.
module tb_ultrasonic_sensor_emulator;

  // 1 MHz: cycles_per_cm = 2000000/343/100 = 58, one cycle per microsecond
  localparam int unsigned CLK_HZ  = 1000000;
  localparam int unsigned DW      = 9;
  localparam int unsigned MAXR    = 20;
  localparam int unsigned MINT_US = 10;
  localparam int unsigned DLY_US  = 25;
  localparam int unsigned TMO_US  = 1500;
  localparam int unsigned HLD_US  = 300;

  localparam int CPCM  = 58;
  localparam int MINT  = 10;
  localparam int DLY   = 25;
  localparam int TMO   = 1500;
  localparam int HLD   = 300;
  localparam int LIMIT = 5000;
`ifdef ULTRASONIC_EMU_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clk;
  logic          rst;
  logic          trig;
  logic [DW-1:0] distance_cm;
  logic          echo;
  logic          busy;
  logic          short_trig;

  int n_vec = 0;
  int n_err = 0;
  int short_cnt = 0;
  int rise_cnt = 0;
  logic echo_prev = 1'b0;

  ultrasonic_sensor_emulator #(
    .clk_frequency    (CLK_HZ),
    .distance_width   (DW),
    .max_range_cm     (MAXR),
    .min_trig_us      (MINT_US),
    .response_delay_us(DLY_US),
    .timeout_us       (TMO_US),
    .holdoff_us       (HLD_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (short_trig === 1'b1) short_cnt++;
    if (echo === 1'b1 && echo_prev === 1'b0) rise_cnt++;
    echo_prev = echo;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // trig high for exactly n rising edges; returns just after the edge where it goes low
  task automatic pulse_trig(input int n);
    @(posedge clk); #1 trig = 1'b1;
    repeat (n) @(posedge clk);
    #1 trig = 1'b0;
  endtask

  task automatic run_until_echo(input logic lvl, output int n);
    n = 0;
    while (echo !== lvl && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_until_busy(input logic lvl, output int n);
    n = 0;
    while (busy !== lvl && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Full valid transaction: latency from trig drop to echo rise, echo width, holdoff
  task automatic txn(input int d, output int lat, output int w, output int h);
    distance_cm = DW'(d);
    pulse_trig(MINT);
    run_until_echo(1'b1, lat);
    run_until_echo(1'b0, w);
    run_until_busy(1'b0, h);
  endtask

  initial begin
    int lat, w, h, s0, r0;
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_echo", echo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_short", short_trig, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Nominal 10 cm echo with busy and latency checks
    distance_cm = DW'(10);
    s0 = short_cnt;
    pulse_trig(MINT);
    check_eq("busy_before_fall", busy, 0);
    repeat (1 + SL) @(posedge clk);
    #1;
    check_eq("busy_on_fall", busy, 1);
    run_until_echo(1'b1, lat);
    check_eq("lat_10cm", lat + 1 + SL, DLY + 1 + SL);
    run_until_echo(1'b0, w);
    check_eq("width_10cm", w, 10 * CPCM);
    check_eq("busy_after_echo", busy, 1);
    run_until_busy(1'b0, h);
    check_eq("holdoff_10cm", h, HLD);
    check_eq("no_short_valid", short_cnt - s0, 0);

    // One cycle too short: single short_trig pulse, nothing else
    s0 = short_cnt;
    r0 = rise_cnt;
    pulse_trig(MINT - 1);
    repeat (DLY + SL + 20) @(posedge clk);
    #1;
    check_eq("short_pulses", short_cnt - s0, 1);
    check_eq("short_no_echo", rise_cnt - r0, 0);
    check_eq("short_busy", busy, 0);

    // Range boundaries
    txn(MAXR + 1, lat, w, h);
    check_eq("lat_over", lat, DLY + 1 + SL);
    check_eq("width_over", w, TMO);
    check_eq("hold_over", h, HLD);
    txn(0, lat, w, h);
    check_eq("width_zero", w, CPCM);
    txn(MAXR, lat, w, h);
    check_eq("width_max", w, MAXR * CPCM);
    txn(1, lat, w, h);
    check_eq("width_one", w, CPCM);

    // Distance change mid-echo and retrigger during holdoff are both ignored
    distance_cm = DW'(5);
    s0 = short_cnt;
    pulse_trig(MINT);
    run_until_echo(1'b1, lat);
    distance_cm = DW'(15);
    run_until_echo(1'b0, w);
    check_eq("width_latched", w, 5 * CPCM);
    r0 = rise_cnt;
    pulse_trig(MINT);
    run_until_busy(1'b0, h);
    check_eq("hold_with_retrig", h + MINT + 1, HLD);
    repeat (DLY + SL + 40) @(posedge clk);
    #1;
    check_eq("retrig_no_echo", rise_cnt - r0, 0);
    check_eq("retrig_no_short", short_cnt - s0, 0);
    check_eq("retrig_idle_busy", busy, 0);

    // Asynchronous reset during echo
    distance_cm = DW'(10);
    pulse_trig(MINT);
    run_until_echo(1'b1, lat);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("rst_mid_echo", echo, 0);
    check_eq("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    txn(3, lat, w, h);
    check_eq("post_rst_lat", lat, DLY + 1 + SL);
    check_eq("post_rst_width", w, 3 * CPCM);
    check_eq("post_rst_hold", h, HLD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
